// File: rtl/mem_stage_lsu_pkg.sv
// mem_stage_lsu_pkg
//   Shared encodings for the MEM stage:
//   - load/store type codes as produced by the decoder,
//   - LSU FSM state encoding,
//   - common constants.
//   It also holds a small helper that classifies a load type.
package mem_stage_lsu_pkg;

   typedef enum logic [2:0] {
      LD_NONE = 3'd0,
      LD_LB   = 3'd1,
      LD_LH   = 3'd2,
      LD_LW   = 3'd3,
      LD_LBU  = 3'd4,
      LD_LHU  = 3'd5
   } load_t;

   typedef enum logic [1:0] {
      ST_NONE = 2'd0,
      ST_SB   = 2'd1,
      ST_SH   = 2'd2,
      ST_SW   = 2'd3
   } store_t;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_REQ    = 2'd1,
      S_WAIT_R = 2'd2
   } state_t;

   localparam logic [31:0] ZeroWord       = 32'h0000_0000;
   localparam logic        RedirectEnable = 1'b1;

   // Codes 6 and 7 are unused by the decoder and are treated as non-memory.
   function automatic logic is_load_type(input logic [2:0] lt);
      return (lt != 3'(LD_NONE)) && (lt <= 3'(LD_LHU));
   endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// lsu_align
//   Purely combinational data-path helper for the LSU.
//   - Store side: byte enables and lane-replicated write data.
//   - Load side: byte/half extraction and sign/zero extension.
//   - Misalignment check for the captured access.
// Ports:
//   addr_lo    in   low two address bits of the effective address
//   loadtype   in   load type code (load_t)
//   storetype  in   store type code (store_t)
//   store_data in   raw store data
//   rdata      in   data returned by memory
//   be         out  byte enables for a store
//   wdata      out  replicated store data
//   load_data  out  extracted and extended load result
//   misalign   out  access violates its natural alignment
module lsu_align
   import mem_stage_lsu_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [1:0]        addr_lo,
   input  logic [2:0]        loadtype,
   input  logic [1:0]        storetype,
   input  logic [DATA_W-1:0] store_data,
   input  logic [31:0]       rdata,
   output logic [3:0]        be,
   output logic [31:0]       wdata,
   output logic [DATA_W-1:0] load_data,
   output logic              misalign
);

   load_t       lt;
   store_t      st;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign lt = load_t'(loadtype);
   assign st = store_t'(storetype);

   always_comb begin
      case (addr_lo)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
   end

   always_comb begin
      load_data = '0;
      case (lt)
         LD_LB:   load_data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
         LD_LH:   load_data = {{(DATA_W-16){half_sel[15]}}, half_sel};
         LD_LW:   load_data = DATA_W'(rdata);
         LD_LBU:  load_data = {{(DATA_W-8){1'b0}}, byte_sel};
         LD_LHU:  load_data = {{(DATA_W-16){1'b0}}, half_sel};
         default: load_data = '0;
      endcase
   end

   always_comb begin
      be    = 4'b0000;
      wdata = ZeroWord;
      case (st)
         ST_SB: begin
            be    = 4'b0001 << addr_lo;
            wdata = {4{store_data[7:0]}};
         end
         ST_SH: begin
            be    = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata = {2{store_data[15:0]}};
         end
         ST_SW: begin
            be    = 4'b1111;
            wdata = store_data[31:0];
         end
         default: ;
      endcase
   end

   // Byte accesses never misalign.
   always_comb begin
      misalign = 1'b0;
      if (lt == LD_LH || lt == LD_LHU || st == ST_SH)
         misalign = addr_lo[0];
      else if (lt == LD_LW || st == ST_SW)
         misalign = |addr_lo;
   end

endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu
//   MEM stage of the RISC-V core.
//   - Registers the EX outputs into a stage register.
//   - Runs the data-memory req/gnt/rvalid handshake for loads and stores.
//   - Drives the GPR/CSR redirect buses back to EX.
//   - Stalls IF/ID/EX while a memory access is in flight.
//   - Hands registered results to WB.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   ex_*                EX results, write-back control, load/store info, CSR bundle
//   mem_stall           freeze IF/ID/EX
//   mem_ex_op*          GPR redirect (data/addr/valid), from the stage register
//   mem_ex_csr_*        CSR redirect (data/addr/valid), from the stage register
//   dmem_*              data-memory request channel and response
//   wb_*                registered write-back outputs
//   misalign_o          one-cycle pulse for a misaligned access
module mem_stage_lsu
   import mem_stage_lsu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int CSR_AW = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] ex_result,
   input  logic              ex_wr_bck_en,
   input  logic [REG_AW-1:0] ex_wr_reg_addr,
   input  logic [31:0]       ex_pc,
   input  logic [2:0]        ex_loadtype,
   input  logic [1:0]        ex_storetype,
   input  logic [DATA_W-1:0] ex_store_data,
   input  logic              ex_isload,
   input  logic [DATA_W-1:0] ex_csr_wr_data,
   input  logic [CSR_AW-1:0] ex_csr_wr_addr,
   input  logic              ex_csr_wr_en,
   output logic              mem_stall,
   output logic [DATA_W-1:0] mem_ex_op,
   output logic [REG_AW-1:0] mem_ex_op_addr,
   output logic              mem_ex_op_en,
   output logic [DATA_W-1:0] mem_ex_csr_data,
   output logic [CSR_AW-1:0] mem_ex_csr_addr,
   output logic              mem_ex_csr_en,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [31:0]       dmem_addr,
   output logic [3:0]        dmem_be,
   output logic [31:0]       dmem_wdata,
   input  logic              dmem_gnt,
   input  logic              dmem_rvalid,
   input  logic [31:0]       dmem_rdata,
   output logic              wb_wr_en,
   output logic [REG_AW-1:0] wb_wr_addr,
   output logic [DATA_W-1:0] wb_wr_data,
   output logic              wb_csr_wr_en,
   output logic [CSR_AW-1:0] wb_csr_wr_addr,
   output logic [DATA_W-1:0] wb_csr_wr_data,
   output logic [31:0]       wb_pc,
   output logic              misalign_o
);

   // Stage register
   logic [DATA_W-1:0] s_result, s_store_data, s_csr_data;
   logic [REG_AW-1:0] s_rd;
   logic [CSR_AW-1:0] s_csr_addr;
   logic [31:0]       s_pc;
   logic [2:0]        s_lt;
   logic [1:0]        s_st;
   logic              s_wb_en, s_isload, s_csr_en;

   state_t            state;
   logic              is_ld, is_mem;
   logic [3:0]        al_be;
   logic [31:0]       al_wdata;
   logic [DATA_W-1:0] al_ldata;
   logic              al_misalign;

   assign is_ld  = is_load_type(s_lt);
   assign is_mem = is_ld || (s_st != 2'(ST_NONE));

   lsu_align #(.DATA_W(DATA_W)) u_align (
      .addr_lo    (s_result[1:0]),
      .loadtype   (s_lt),
      .storetype  (s_st),
      .store_data (s_store_data),
      .rdata      (dmem_rdata),
      .be         (al_be),
      .wdata      (al_wdata),
      .load_data  (al_ldata),
      .misalign   (al_misalign)
   );

   // Stall drops in the cycle the FSM heads back to IDLE, so the next op is
   // captured on that same edge (back-to-back memory ops lose no cycle).
   always_comb begin
      case (state)
         S_IDLE:   mem_stall = is_mem && !al_misalign;
         S_REQ:    mem_stall = !(dmem_gnt && !is_ld);
         S_WAIT_R: mem_stall = !dmem_rvalid;
         default:  mem_stall = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s_result     <= '0;
         s_wb_en      <= 1'b0;
         s_rd         <= '0;
         s_pc         <= '0;
         s_lt         <= 3'(LD_NONE);
         s_st         <= 2'(ST_NONE);
         s_store_data <= '0;
         s_isload     <= 1'b0;
         s_csr_data   <= '0;
         s_csr_addr   <= '0;
         s_csr_en     <= 1'b0;
      end else if (!mem_stall) begin
         s_result     <= ex_result;
         s_wb_en      <= ex_wr_bck_en;
         s_rd         <= ex_wr_reg_addr;
         s_pc         <= ex_pc;
         s_lt         <= ex_loadtype;
         s_st         <= ex_storetype;
         s_store_data <= ex_store_data;
         s_isload     <= ex_isload;
         s_csr_data   <= ex_csr_wr_data;
         s_csr_addr   <= ex_csr_wr_addr;
         s_csr_en     <= ex_csr_wr_en;
      end
   end

   // LSU FSM with registered bus and write-back outputs. Write enables are
   // single-cycle: they default low and are raised only on the retire edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_IDLE;
         dmem_req       <= 1'b0;
         dmem_we        <= 1'b0;
         dmem_addr      <= ZeroWord;
         dmem_be        <= 4'b0000;
         dmem_wdata     <= ZeroWord;
         wb_wr_en       <= 1'b0;
         wb_wr_addr     <= '0;
         wb_wr_data     <= '0;
         wb_csr_wr_en   <= 1'b0;
         wb_csr_wr_addr <= '0;
         wb_csr_wr_data <= '0;
         wb_pc          <= ZeroWord;
         misalign_o     <= 1'b0;
      end else begin
         wb_wr_en     <= 1'b0;
         wb_csr_wr_en <= 1'b0;
         misalign_o   <= 1'b0;
         case (state)
            S_IDLE: begin
               if (is_mem && al_misalign) begin
                  misalign_o <= 1'b1;
                  wb_pc      <= s_pc;
               end else if (is_mem) begin
                  state      <= S_REQ;
                  dmem_req   <= 1'b1;
                  dmem_we    <= !is_ld;
                  dmem_addr  <= {s_result[31:2], 2'b00};
                  // Loads read the whole word; the lane is picked on return.
                  dmem_be    <= is_ld ? 4'b1111 : al_be;
                  dmem_wdata <= is_ld ? ZeroWord : al_wdata;
               end else begin
                  wb_wr_en       <= s_wb_en;
                  wb_wr_addr     <= s_rd;
                  wb_wr_data     <= s_result;
                  wb_csr_wr_en   <= s_csr_en;
                  wb_csr_wr_addr <= s_csr_addr;
                  wb_csr_wr_data <= s_csr_data;
                  wb_pc          <= s_pc;
               end
            end
            S_REQ: begin
               // rvalid is not looked at here, even alongside gnt.
               if (dmem_gnt) begin
                  dmem_req   <= 1'b0;
                  dmem_we    <= 1'b0;
                  dmem_addr  <= ZeroWord;
                  dmem_be    <= 4'b0000;
                  dmem_wdata <= ZeroWord;
                  if (is_ld) begin
                     state <= S_WAIT_R;
                  end else begin
                     state          <= S_IDLE;
                     wb_csr_wr_en   <= s_csr_en;
                     wb_csr_wr_addr <= s_csr_addr;
                     wb_csr_wr_data <= s_csr_data;
                     wb_pc          <= s_pc;
                  end
               end
            end
            S_WAIT_R: begin
               if (dmem_rvalid) begin
                  state          <= S_IDLE;
                  wb_wr_en       <= s_wb_en;
                  wb_wr_addr     <= s_rd;
                  wb_wr_data     <= al_ldata;
                  wb_csr_wr_en   <= s_csr_en;
                  wb_csr_wr_addr <= s_csr_addr;
                  wb_csr_wr_data <= s_csr_data;
                  wb_pc          <= s_pc;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Redirect buses: loads never forward, their data is not known yet.
   assign mem_ex_op       = s_result;
   assign mem_ex_op_addr  = s_rd;
   assign mem_ex_op_en    = (s_wb_en && (s_rd != '0) && !s_isload) ? RedirectEnable : 1'b0;
   assign mem_ex_csr_data = s_csr_data;
   assign mem_ex_csr_addr = s_csr_addr;
   assign mem_ex_csr_en   = s_csr_en;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu
//   Directed plus randomized bench for mem_stage_lsu. Each operation is
//   pushed through the stage and the bus/write-back behaviour is compared
//   with values derived from the ISA-level meaning of the access.
module tb_mem_stage_lsu;

   typedef struct packed {
      logic [31:0] result;
      logic        wb_en;
      logic [4:0]  rd;
      logic [31:0] pc;
      logic [2:0]  lt;
      logic [1:0]  st;
      logic [31:0] sd;
      logic [31:0] csr_d;
      logic [11:0] csr_a;
      logic        csr_en;
   } op_t;

   logic        clk, rst;
   logic [31:0] ex_result, ex_pc, ex_store_data, ex_csr_wr_data;
   logic        ex_wr_bck_en, ex_isload, ex_csr_wr_en;
   logic [4:0]  ex_wr_reg_addr;
   logic [2:0]  ex_loadtype;
   logic [1:0]  ex_storetype;
   logic [11:0] ex_csr_wr_addr;
   logic        mem_stall, mem_ex_op_en, mem_ex_csr_en;
   logic [31:0] mem_ex_op, mem_ex_csr_data;
   logic [4:0]  mem_ex_op_addr;
   logic [11:0] mem_ex_csr_addr;
   logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;
   logic        wb_wr_en, wb_csr_wr_en, misalign_o;
   logic [4:0]  wb_wr_addr;
   logic [31:0] wb_wr_data, wb_csr_wr_data, wb_pc;
   logic [11:0] wb_csr_wr_addr;

   int n_assert = 0;
   int n_fail   = 0;

   mem_stage_lsu dut (
      .clk(clk), .rst(rst),
      .ex_result(ex_result), .ex_wr_bck_en(ex_wr_bck_en), .ex_wr_reg_addr(ex_wr_reg_addr),
      .ex_pc(ex_pc), .ex_loadtype(ex_loadtype), .ex_storetype(ex_storetype),
      .ex_store_data(ex_store_data), .ex_isload(ex_isload),
      .ex_csr_wr_data(ex_csr_wr_data), .ex_csr_wr_addr(ex_csr_wr_addr), .ex_csr_wr_en(ex_csr_wr_en),
      .mem_stall(mem_stall), .mem_ex_op(mem_ex_op), .mem_ex_op_addr(mem_ex_op_addr),
      .mem_ex_op_en(mem_ex_op_en), .mem_ex_csr_data(mem_ex_csr_data),
      .mem_ex_csr_addr(mem_ex_csr_addr), .mem_ex_csr_en(mem_ex_csr_en),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
      .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
      .dmem_rdata(dmem_rdata),
      .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr), .wb_wr_data(wb_wr_data),
      .wb_csr_wr_en(wb_csr_wr_en), .wb_csr_wr_addr(wb_csr_wr_addr),
      .wb_csr_wr_data(wb_csr_wr_data), .wb_pc(wb_pc), .misalign_o(misalign_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input op_t o);
      ex_result      = o.result;
      ex_wr_bck_en   = o.wb_en;
      ex_wr_reg_addr = o.rd;
      ex_pc          = o.pc;
      ex_loadtype    = o.lt;
      ex_storetype   = o.st;
      ex_store_data  = o.sd;
      ex_isload      = (o.lt != 3'd0);
      ex_csr_wr_data = o.csr_d;
      ex_csr_wr_addr = o.csr_a;
      ex_csr_wr_en   = o.csr_en;
   endtask

   // ---- reference model: access meaning in bytes and plain arithmetic ----
   function automatic int acc_size(input op_t o);
      if (o.lt == 3'd1 || o.lt == 3'd4 || o.st == 2'd1) return 1;
      if (o.lt == 3'd2 || o.lt == 3'd5 || o.st == 2'd2) return 2;
      return 4;
   endfunction

   function automatic bit m_misaligned(input op_t o);
      return (o.result % acc_size(o)) != 0;
   endfunction

   function automatic logic [3:0] m_be(input op_t o);
      int off;
      if (o.lt != 3'd0) return 4'hF;
      off = int'(o.result % 4);
      case (acc_size(o))
         1:       return 4'(1 << off);
         2:       return 4'(3 << off);
         default: return 4'hF;
      endcase
   endfunction

   function automatic logic [31:0] m_wdata(input op_t o);
      if (o.lt != 3'd0) return 32'h0;
      case (acc_size(o))
         1:       return {24'h0, o.sd[7:0]} * 32'h0101_0101;
         2:       return {16'h0, o.sd[15:0]} * 32'h0001_0001;
         default: return o.sd;
      endcase
   endfunction

   function automatic logic [31:0] m_load(input op_t o, input logic [31:0] rdata);
      int          n, off;
      logic [31:0] v, mask;
      bit          sgn;
      n   = acc_size(o);
      sgn = (o.lt == 3'd1 || o.lt == 3'd2);
      off = int'(o.result % 4);
      off = off - (off % n);
      v   = rdata >> (8 * off);
      if (n == 4) return v;
      mask = (32'd1 << (8 * n)) - 32'd1;
      v    = v & mask;
      if (sgn && v[8*n-1]) v = v | ~mask;
      return v;
   endfunction

   // Push one op through the stage. follow is what EX presents once the op
   // has been captured (normally a bubble). Returns one cycle after the op's
   // retire edge, with follow captured on that edge.
   task automatic run_op(input string nm, input op_t o, input op_t follow,
                         input int gd, input int rd_dly, input bit rv_in_req,
                         input logic [31:0] rdata);
      bit is_ld, is_mem;
      is_ld  = (o.lt != 3'd0);
      is_mem = is_ld || (o.st != 2'd0);
      drive(o);
      step();
      drive(follow);
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
      #1;
      chk({nm, ".op_en"}, 32'(mem_ex_op_en), 32'(o.wb_en && o.rd != 5'd0 && !is_ld));
      chk({nm, ".op"}, mem_ex_op, o.result);
      chk({nm, ".op_addr"}, 32'(mem_ex_op_addr), 32'(o.rd));
      chk({nm, ".csr_en"}, 32'(mem_ex_csr_en), 32'(o.csr_en));
      if (!is_mem) begin
         chk({nm, ".stall"}, 32'(mem_stall), 32'd0);
         step();
         chk({nm, ".wb_en"}, 32'(wb_wr_en), 32'(o.wb_en));
         chk({nm, ".wb_addr"}, 32'(wb_wr_addr), 32'(o.rd));
         chk({nm, ".wb_data"}, wb_wr_data, o.result);
         chk({nm, ".wb_csr_en"}, 32'(wb_csr_wr_en), 32'(o.csr_en));
         chk({nm, ".wb_csr_data"}, wb_csr_wr_data, o.csr_d);
         chk({nm, ".wb_csr_addr"}, 32'(wb_csr_wr_addr), 32'(o.csr_a));
         chk({nm, ".wb_pc"}, wb_pc, o.pc);
         return;
      end
      if (m_misaligned(o)) begin
         chk({nm, ".mis_stall"}, 32'(mem_stall), 32'd0);
         step();
         chk({nm, ".misalign"}, 32'(misalign_o), 32'd1);
         chk({nm, ".mis_wb_en"}, 32'(wb_wr_en), 32'd0);
         chk({nm, ".mis_csr_en"}, 32'(wb_csr_wr_en), 32'd0);
         chk({nm, ".mis_req"}, 32'(dmem_req), 32'd0);
         step();
         chk({nm, ".misalign_pulse"}, 32'(misalign_o), 32'd0);
         chk({nm, ".mis_req2"}, 32'(dmem_req), 32'd0);
         return;
      end
      chk({nm, ".idle_stall"}, 32'(mem_stall), 32'd1);
      step();
      for (int k = 0; k <= gd; k++) begin
         chk({nm, ".req"}, 32'(dmem_req), 32'd1);
         chk({nm, ".we"}, 32'(dmem_we), 32'(!is_ld));
         chk({nm, ".addr"}, dmem_addr, o.result & 32'hFFFF_FFFC);
         chk({nm, ".be"}, 32'(dmem_be), 32'(m_be(o)));
         chk({nm, ".wdata"}, dmem_wdata, m_wdata(o));
         chk({nm, ".req_wb_en"}, 32'(wb_wr_en), 32'd0);
         chk({nm, ".req_op_en"}, 32'(mem_ex_op_en), 32'(o.wb_en && o.rd != 5'd0 && !is_ld));
         if (k == gd) begin
            dmem_gnt = 1'b1;
            if (rv_in_req) begin dmem_rvalid = 1'b1; dmem_rdata = $urandom; end
         end
         #1;
         chk({nm, ".req_stall"}, 32'(mem_stall), (k == gd) ? 32'(is_ld) : 32'd1);
         step();
         dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
      end
      chk({nm, ".post_gnt_req"}, 32'(dmem_req), 32'd0);
      chk({nm, ".post_gnt_wb_en"}, 32'(wb_wr_en), 32'd0);
      if (!is_ld) return;
      for (int j = 0; j <= rd_dly; j++) begin
         chk({nm, ".wait_req"}, 32'(dmem_req), 32'd0);
         chk({nm, ".wait_wb_en"}, 32'(wb_wr_en), 32'd0);
         if (j == rd_dly) begin dmem_rvalid = 1'b1; dmem_rdata = rdata; end
         else dmem_rdata = $urandom;
         #1;
         chk({nm, ".wait_stall"}, 32'(mem_stall), (j == rd_dly) ? 32'd0 : 32'd1);
         step();
         dmem_rvalid = 1'b0;
      end
      chk({nm, ".ld_wb_en"}, 32'(wb_wr_en), 32'(o.wb_en));
      chk({nm, ".ld_wb_addr"}, 32'(wb_wr_addr), 32'(o.rd));
      chk({nm, ".ld_wb_data"}, wb_wr_data, m_load(o, rdata));
      chk({nm, ".ld_wb_pc"}, wb_pc, o.pc);
   endtask

   function automatic op_t mk(input logic [31:0] res, input logic wb, input logic [4:0] rd,
                              input logic [2:0] lt, input logic [1:0] st, input logic [31:0] sd);
      op_t o;
      o        = '0;
      o.result = res;
      o.wb_en  = wb;
      o.rd     = rd;
      o.pc     = 32'h0000_0100 + res;
      o.lt     = lt;
      o.st     = st;
      o.sd     = sd;
      return o;
   endfunction

   initial begin
      op_t bub, o, f;
      bub = '0;
      rst = 1'b1;
      drive(bub);
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
      step(); step();
      chk("rst.stall", 32'(mem_stall), 32'd0);
      chk("rst.req", 32'(dmem_req), 32'd0);
      chk("rst.we", 32'(dmem_we), 32'd0);
      chk("rst.addr", dmem_addr, 32'd0);
      chk("rst.be", 32'(dmem_be), 32'd0);
      chk("rst.wdata", dmem_wdata, 32'd0);
      chk("rst.wb_en", 32'(wb_wr_en), 32'd0);
      chk("rst.wb_data", wb_wr_data, 32'd0);
      chk("rst.csr_en", 32'(wb_csr_wr_en), 32'd0);
      chk("rst.pc", wb_pc, 32'd0);
      chk("rst.misalign", 32'(misalign_o), 32'd0);
      chk("rst.op_en", 32'(mem_ex_op_en), 32'd0);
      chk("rst.ex_csr_en", 32'(mem_ex_csr_en), 32'd0);
      rst = 1'b0;

      // ADD x5 = 0x10, with a CSR write riding along
      o = mk(32'h10, 1'b1, 5'd5, 3'd0, 2'd0, 32'h0);
      o.csr_en = 1'b1; o.csr_a = 12'h305; o.csr_d = 32'hCAFE_0001;
      run_op("add", o, bub, 0, 0, 1'b0, 32'h0);
      run_op("sb", mk(32'h1003, 1'b0, 5'd0, 3'd0, 2'd1, 32'h0000_00A5), bub, 0, 0, 1'b0, 32'h0);
      run_op("lh", mk(32'h2002, 1'b1, 5'd7, 3'd2, 2'd0, 32'h0), bub, 0, 0, 1'b0, 32'h8001_1234);
      run_op("lbu", mk(32'h2001, 1'b1, 5'd8, 3'd4, 2'd0, 32'h0), bub, 1, 0, 1'b0, 32'h0000_F000);
      run_op("lw_slow", mk(32'h2468, 1'b1, 5'd9, 3'd3, 2'd0, 32'h0), bub, 3, 2, 1'b1, 32'h1357_9BDF);
      run_op("lw_mis", mk(32'h3001, 1'b1, 5'd10, 3'd3, 2'd0, 32'h0), bub, 0, 0, 1'b0, 32'h0);
      run_op("sh_mis", mk(32'h3005, 1'b0, 5'd0, 3'd0, 2'd2, 32'h1234), bub, 0, 0, 1'b0, 32'h0);

      // Back-to-back: ADD is presented during the SW stall, captured on its retire edge
      f = mk(32'h77, 1'b1, 5'd11, 3'd0, 2'd0, 32'h0);
      run_op("sw_b2b", mk(32'h4008, 1'b0, 5'd0, 3'd0, 2'd3, 32'hDEAD_BEEF), f, 2, 0, 1'b0, 32'h0);
      drive(bub);
      step();
      chk("b2b.wb_en", 32'(wb_wr_en), 32'd1);
      chk("b2b.wb_addr", 32'(wb_wr_addr), 32'd11);
      chk("b2b.wb_data", wb_wr_data, 32'h77);

      // Reset while waiting for read data; the late rvalid must be dropped
      drive(mk(32'h5000, 1'b1, 5'd12, 3'd3, 2'd0, 32'h0));
      step();
      drive(bub);
      step();
      chk("rstw.req", 32'(dmem_req), 32'd1);
      dmem_gnt = 1'b1;
      step();
      dmem_gnt = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
      #1;
      chk("rstw.stall", 32'(mem_stall), 32'd0);
      step();
      dmem_rvalid = 1'b0;
      chk("rstw.wb_en", 32'(wb_wr_en), 32'd0);
      chk("rstw.req", 32'(dmem_req), 32'd0);
      run_op("rstw.add", mk(32'h99, 1'b1, 5'd13, 3'd0, 2'd0, 32'h0), bub, 0, 0, 1'b0, 32'h0);

      // Randomized mix
      for (int i = 0; i < 60; i++) begin
         int kind;
         kind = int'($urandom_range(0, 2));
         case (kind)
            0: begin
               o = mk($urandom, 1'(int'($urandom_range(0, 1))), 5'($urandom_range(0, 31)), 3'd0, 2'd0, 32'h0);
               o.csr_en = 1'(int'($urandom_range(0, 1)));
               o.csr_a  = 12'($urandom);
               o.csr_d  = $urandom;
            end
            1: o = mk($urandom, 1'b1, 5'($urandom_range(1, 31)), 3'($urandom_range(1, 5)), 2'd0, 32'h0);
            default: o = mk($urandom, 1'b0, 5'd0, 3'd0, 2'($urandom_range(1, 3)), $urandom);
         endcase
         run_op("rnd", o, bub, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                1'(int'($urandom_range(0, 1))), $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
